// File: rtl/decode_stage.sv
// RV32I/RV64I registered decode stage with a two-entry (output + skid) buffer and flush.
// Optional encoding checks are enabled by defining DECODE_ILLEGAL_CHECK_EN.
`timescale 1ns/1ps
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [1:0]      pcsel,
    output logic            alu1sel,
    output logic            alu2sel,
    output logic [1:0]      wbsel,
    output logic            regwrite,
    output logic            memwrite,
    output logic            illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [1:0]      pcsel;
        logic            alu1sel;
        logic            alu2sel;
        logic [1:0]      wbsel;
        logic            regwrite;
        logic            memwrite;
        logic            illegal;
    } bundle_t;

    function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
        logic signed [XLEN-1:0] w;
        w = XLEN'(v);
        return w;
    endfunction

`ifdef DECODE_ILLEGAL_CHECK_EN
    function automatic logic illegal_enc(input logic [31:0] ins);
        logic       bad;
        logic [2:0] f3;
        f3  = ins[14:12];
        bad = (ins[1:0] != 2'b11);
        case (ins[6:0])
            OPC_LOAD:   bad = bad | ((XLEN == 64) ? (f3 == 3'd7) : (f3 == 3'd3 || f3 >= 3'd6));
            OPC_STORE:  bad = bad | ((XLEN == 64) ? (f3 >= 3'd4) : (f3 >= 3'd3));
            OPC_BRANCH: bad = bad | (f3 == 3'd2 || f3 == 3'd3);
            OPC_JALR:   bad = bad | (f3 != 3'd0);
            OPC_OP:     bad = bad | (ins[31:25] != 7'b0000000 && ins[31:25] != 7'b0100000);
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OPIMM, OPC_FENCE, OPC_SYSTEM: ;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction
`endif

    function automatic bundle_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        bundle_t            b;
        logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_u = {ins[31:12], 12'b0};
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        b        = '0;
        b.pc     = pc;
        b.opcode = ins[6:0];
        b.funct3 = ins[14:12];
        b.funct7 = ins[31:25];
        case (ins[6:0])
            OPC_LUI: begin
                b.rd = ins[11:7]; b.imm = sext(imm_u);
                b.alu2sel = 1'b1; b.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                b.rd = ins[11:7]; b.imm = sext(imm_u);
                b.alu1sel = 1'b1; b.alu2sel = 1'b1; b.regwrite = 1'b1;
            end
            OPC_JAL: begin
                b.rd = ins[11:7]; b.imm = sext(imm_j);
                b.pcsel = 2'd1; b.wbsel = 2'd2; b.regwrite = 1'b1;
            end
            OPC_JALR: begin
                b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.imm = sext(imm_i);
                b.pcsel = 2'd2; b.alu2sel = 1'b1; b.wbsel = 2'd2; b.regwrite = 1'b1;
            end
            OPC_BRANCH: begin
                b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.imm = sext(imm_b);
                b.pcsel = 2'd3;
            end
            OPC_LOAD: begin
                b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.imm = sext(imm_i);
                b.alu2sel = 1'b1; b.wbsel = 2'd1; b.regwrite = 1'b1;
            end
            OPC_STORE: begin
                b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.imm = sext(imm_s);
                b.alu2sel = 1'b1; b.memwrite = 1'b1;
            end
            OPC_OPIMM: begin
                b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.imm = sext(imm_i);
                b.alu2sel = 1'b1; b.regwrite = 1'b1;
            end
            OPC_OP: begin
                b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
                b.regwrite = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.imm = sext(imm_i);
            end
            default: begin
                // Unknown encodings keep raw register fields for debug visibility.
                b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
            end
        endcase
        if (b.rd == 5'd0) b.regwrite = 1'b0;
`ifdef DECODE_ILLEGAL_CHECK_EN
        b.illegal = illegal_enc(ins);
        if (b.illegal) begin
            b.regwrite = 1'b0;
            b.memwrite = 1'b0;
            b.pcsel    = 2'd0;
        end
`endif
        return b;
    endfunction

    bundle_t w_dec;
    logic    w_accept;
    logic    w_drain;
    bundle_t r_bundle_p1;
    bundle_t r_skid_p1;
    logic    r_vld_p1;
    logic    r_skid_vld_p1;
    logic    r_in_ready;

    assign w_dec    = decode(in_ins, in_pc);
    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = !r_vld_p1 || out_ready;

    // Stage p0 -> p1: output register fed from skid first, then from the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bundle_p1   <= '0;
            r_skid_p1     <= '0;
            r_vld_p1      <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
            r_in_ready    <= 1'b0;
        end else if (flush) begin
            r_vld_p1      <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
            r_in_ready    <= 1'b1;
        end else if (w_drain) begin
            if (r_skid_vld_p1) begin
                r_bundle_p1   <= r_skid_p1;
                r_vld_p1      <= 1'b1;
                r_skid_vld_p1 <= w_accept;
                r_in_ready    <= !w_accept;
                if (w_accept) r_skid_p1 <= w_dec;
            end else begin
                r_vld_p1   <= w_accept;
                r_in_ready <= 1'b1;
                if (w_accept) r_bundle_p1 <= w_dec;
            end
        end else if (w_accept) begin
            r_skid_p1     <= w_dec;
            r_skid_vld_p1 <= 1'b1;
            r_in_ready    <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_vld_p1;
    assign out_pc    = r_bundle_p1.pc;
    assign opcode    = r_bundle_p1.opcode;
    assign funct3    = r_bundle_p1.funct3;
    assign funct7    = r_bundle_p1.funct7;
    assign rs1       = r_bundle_p1.rs1;
    assign rs2       = r_bundle_p1.rs2;
    assign rd        = r_bundle_p1.rd;
    assign imm       = r_bundle_p1.imm;
    assign pcsel     = r_bundle_p1.pcsel;
    assign alu1sel   = r_bundle_p1.alu1sel;
    assign alu2sel   = r_bundle_p1.alu2sel;
    assign wbsel     = r_bundle_p1.wbsel;
    assign regwrite  = r_bundle_p1.regwrite;
    assign memwrite  = r_bundle_p1.memwrite;
    assign illegal   = r_bundle_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32): decode vectors, skid stall, flush and reset.
`timescale 1ns/1ps
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_ins, in_pc, out_pc, imm;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  pcsel, wbsel;
    logic        alu1sel, alu2sel, regwrite, memwrite, illegal;

    int checks = 0;
    int errors = 0;

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .pcsel(pcsel), .alu1sel(alu1sel), .alu2sel(alu2sel), .wbsel(wbsel),
        .regwrite(regwrite), .memwrite(memwrite), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_ins   = ins;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_imm", imm, 0);
        chk("rst_ctrl", {pcsel, alu1sel, alu2sel, wbsel, regwrite, memwrite, illegal}, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // addi x1,x0,5
        drive(1'b1, 32'h00500093, 32'h100); tick();
        chk("addi_valid", out_valid, 1);
        chk("addi_rd", rd, 1);
        chk("addi_rs1", rs1, 0);
        chk("addi_imm", imm, 5);
        chk("addi_ctrl", {pcsel, alu1sel, alu2sel, wbsel, regwrite, memwrite}, 8'b00_0_1_00_1_0);
        chk("addi_pc", out_pc, 32'h100);

        // beq x0,x0,-4
        drive(1'b1, 32'hFE000EE3, 32'h104); tick();
        chk("beq_valid", out_valid, 1);
        chk("beq_imm", imm, 32'hFFFFFFFC);
        chk("beq_pcsel", pcsel, 3);
        chk("beq_writes", {regwrite, memwrite, rd}, 0);
        chk("beq_pc", out_pc, 32'h104);

        // jal x0,0
        drive(1'b1, 32'h0000006F, 32'h108); tick();
        chk("jal0_ctrl", {pcsel, wbsel, regwrite}, 5'b01_10_0);
        chk("jal0_imm", imm, 0);

        // jal x1,8
        drive(1'b1, 32'h008000EF, 32'h10C); tick();
        chk("jal1_imm", imm, 8);
        chk("jal1_ctrl", {rd, pcsel, wbsel, regwrite}, {5'd1, 2'd1, 2'd2, 1'b1});

        // sw x2,12(x1)
        drive(1'b1, 32'h0020A623, 32'h110); tick();
        chk("sw_imm", imm, 12);
        chk("sw_regs", {rs1, rs2, rd}, {5'd1, 5'd2, 5'd0});
        chk("sw_ctrl", {alu2sel, memwrite, regwrite, wbsel}, 5'b1_1_0_00);

        // lui x5,0x12345 (raw rs1 bits are nonzero)
        drive(1'b1, 32'h123452B7, 32'h114); tick();
        chk("lui_imm", imm, 32'h12345000);
        chk("lui_rs1", rs1, 0);
        chk("lui_ctrl", {rd, alu1sel, alu2sel, regwrite}, {5'd5, 1'b0, 1'b1, 1'b1});

        // lw x3,-8(x2)
        drive(1'b1, 32'hFF812183, 32'h118); tick();
        chk("lw_imm", imm, 32'hFFFFFFF8);
        chk("lw_ctrl", {rs1, rd, alu2sel, wbsel, regwrite}, {5'd2, 5'd3, 1'b1, 2'd1, 1'b1});

        // add x3,x1,x2
        drive(1'b1, 32'h002081B3, 32'h11C); tick();
        chk("add_imm", imm, 0);
        chk("add_regs", {rs1, rs2, rd}, {5'd1, 5'd2, 5'd3});
        chk("add_ctrl", {alu2sel, regwrite, funct3, funct7}, {1'b0, 1'b1, 3'd0, 7'd0});

        // auipc x4,1
        drive(1'b1, 32'h00001217, 32'h120); tick();
        chk("auipc_imm", imm, 32'h1000);
        chk("auipc_ctrl", {alu1sel, alu2sel, regwrite, wbsel}, 5'b1_1_1_00);

        // all-ones word
        drive(1'b1, 32'hFFFFFFFF, 32'h124); tick();
        chk("ones_illegal", illegal, EXP_ILL);
        chk("ones_ctrl", {regwrite, memwrite, pcsel}, 0);

        drive(1'b0, 32'h0, 32'h0); tick();
        chk("idle_out_valid", out_valid, 0);

        // Back-pressure: A accepted, stall, B into skid, C held off
        drive(1'b1, 32'h00100093, 32'h200); tick();
        chk("stallA_imm", imm, 1);
        out_ready = 1'b0;
        drive(1'b1, 32'h00200113, 32'h204); tick();
        chk("stallB_in_ready", in_ready, 0);
        chk("stallB_hold", {out_valid, imm, out_pc}, {1'b1, 32'd1, 32'h200});
        drive(1'b1, 32'h00300193, 32'h208); tick();
        chk("stallC_hold", {out_valid, imm, rd, out_pc}, {1'b1, 32'd1, 5'd1, 32'h200});
        chk("stallC_in_ready", in_ready, 0);
        out_ready = 1'b1; tick();
        chk("drainB", {out_valid, imm, rd, out_pc}, {1'b1, 32'd2, 5'd2, 32'h204});
        chk("drainB_in_ready", in_ready, 1);
        tick();
        chk("drainC", {out_valid, imm, rd, out_pc}, {1'b1, 32'd3, 5'd3, 32'h208});
        drive(1'b1, 32'h00400213, 32'h20C); tick();
        chk("drainD", {out_valid, imm, rd, out_pc}, {1'b1, 32'd4, 5'd4, 32'h20C});
        drive(1'b0, 32'h0, 32'h0); tick();
        chk("drain_empty", out_valid, 0);

        // Flush with skid full and an instruction presented
        drive(1'b1, 32'h00500293, 32'h300); tick();
        out_ready = 1'b0;
        drive(1'b1, 32'h00600313, 32'h304); tick();
        chk("fl_skid_full", in_ready, 0);
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 32'h00700393, 32'h308); tick();
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0); tick();
        chk("fl_no_leak", out_valid, 0);

        // Flush with in_ready high drops the presented word
        flush = 1'b1;
        drive(1'b1, 32'h00800413, 32'h30C); tick();
        chk("fl2_dropped", out_valid, 0);
        flush = 1'b0;
        drive(1'b1, 32'h00900493, 32'h310); tick();
        chk("fl2_next", {out_valid, imm, out_pc}, {1'b1, 32'd9, 32'h310});

        // Reset mid-operation with skid full
        out_ready = 1'b0;
        drive(1'b1, 32'h00A00513, 32'h314); tick();
        rst = 1'b1;
        drive(1'b1, 32'h00B00593, 32'h318); tick();
        chk("mrst_state", {out_valid, in_ready}, 0);
        chk("mrst_bundle", {out_pc, imm, rd, regwrite}, 0);
        rst = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0); tick();
        chk("mrst_after", {out_valid, in_ready}, 2'b01);
        tick();
        chk("mrst_no_leak", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
